jedro_1_mem_arbiter: RTL
========================

Name: jedro_1_mem_arbiter

Overview:
Arbitrates one single-port, byte-writable, word-organised RAM between two requesters. Requester 0 is the jedro_1 instruction fetch (read-only). Requester 1 is the jedro_1 load/store port (read/write with byte enables). It lets core and program image share one unified memory, using a round-robin grant, fixed one-cycle response routing and an out-of-range error response.

Parameters:
DATA_WIDTH, 32, word width in bits (multiple of 8)
ADDR_WIDTH, 32, byte-address width of both requesters
MEM_WORDS, 1024, RAM depth in words (power of two); byte addresses at or above MEM_WORDS*(DATA_WIDTH/8) are out of range

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
m0_req_i  in  1  fetch request
m0_addr_i  in  ADDR_WIDTH  fetch byte address (word aligned)
m0_gnt_o  out  1  fetch request accepted this cycle
m0_rvalid_o  out  1  fetch response valid
m0_rdata_o  out  DATA_WIDTH  fetch read data
m0_err_o  out  1  fetch response is out-of-range error
m1_req_i  in  1  data request
m1_addr_i  in  ADDR_WIDTH  data byte address (word aligned)
m1_we_i  in  1  1 = write, 0 = read
m1_be_i  in  DATA_WIDTH/8  byte enables for writes
m1_wdata_i  in  DATA_WIDTH  write data
m1_gnt_o  out  1  data request accepted this cycle
m1_rvalid_o  out  1  data response valid (reads and writes)
m1_rdata_o  out  DATA_WIDTH  data read data
m1_err_o  out  1  data response is out-of-range error
ram_en_o  out  1  RAM access strobe
ram_we_o  out  DATA_WIDTH/8  RAM byte write enables; all 0 = read
ram_addr_o  out  $clog2(MEM_WORDS)  RAM word address
ram_wdata_o  out  DATA_WIDTH  RAM write data
ram_rdata_i  in  DATA_WIDTH  RAM read data, valid the cycle after a read strobe

Behaviour:
- Grant is combinational in the request cycle. At most one gnt per cycle. A request is accepted only when gnt=1. The requester holds req/addr/we/be/wdata stable until granted.
- Arbitration: only one requester active -> grant it. Both active -> grant the requester not granted last.
- last_grant register updates on every grant. Reset value selects m1 as last, so m0 (fetch) wins the first conflict.
- Back-to-back grants to the same requester are allowed when the other is idle. One grant per cycle gives full throughput.
- On an in-range grant, in the same cycle:
  - ram_en_o=1
  - ram_addr_o = addr[$clog2(MEM_WORDS)+log2(DATA_WIDTH/8)-1 : log2(DATA_WIDTH/8)]
  - ram_we_o = m1_be_i if m1_we_i, else 0 (m0 always reads)
  - ram_wdata_o = m1_wdata_i
- On no grant, ram_en_o=0 and ram_we_o=0. ram_addr_o and ram_wdata_o are 0 when idle.
- Out-of-range grant: gnt=1 but ram_en_o=0.
- Response register, set at the grant edge: resp_valid, resp_owner, resp_err, resp_is_write.
- Exactly 1 cycle after each grant, the owner sees rvalid_o=1 for one cycle:
  - rdata_o = ram_rdata_i for an in-range read
  - rdata_o = 0 for writes and for errors
  - err_o = resp_err
- The non-owner's rvalid/rdata/err are 0. With back-to-back grants, responses return in grant order, one per cycle.
- Low address bits are ignored (no misalignment check).
- Reset (async, any time, including mid-transaction):
  - all gnt, rvalid, err, ram_en_o, ram_we_o = 0 and all data outputs = 0 immediately
  - pending response discarded, last_grant = m1
  - while rst_i=1, no grants are issued regardless of req
- First grant possible in the first cycle after rst_i deasserts.
- Requests in the same cycle as a response are independent; pipelined.

Test Plan:
- Fetch only: m0_req at 0x8, RAM word 2 = 0x00100093 -> m0_gnt same cycle, ram_addr_o=2, m0_rvalid next cycle with 0x00100093, m1 outputs all 0.
- Conflict: both request continuously for 4 cycles after reset -> grants m0, m1, m0, m1. Each rvalid arrives one cycle after its grant on the correct port.
- Byte write then read: m1 write addr 0x10, be=4'b0010, wdata 0xAABBCCDD over word 0x11223344 -> ram_we_o=0010, m1_rvalid with rdata 0. Subsequent read returns 0x1122CC44.
- Out of range (MEM_WORDS=1024): m1 read at 0x1000 -> m1_gnt=1, ram_en_o=0, next cycle m1_rvalid=1, m1_err_o=1, rdata 0. m0 unaffected.
- Reset mid-op: assert rst_i in the cycle after a grant -> rvalid never pulses, all outputs 0 immediately. After release with both requesting, m0 is granted first.
- Idle fairness: m1 requests 3 consecutive cycles, m0 idle -> 3 consecutive m1 grants. m0 then joins -> m0 granted next.

Source files
------------

// File: rtl/jedro_1_mem_arbiter.sv
// Round-robin arbiter sharing one single-port, byte-writable RAM between the
// jedro_1 instruction fetch (m0) and load/store (m1) ports, one-cycle responses.
module jedro_1_mem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_WORDS  = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         m0_req_i,
  input  logic [ADDR_WIDTH-1:0]        m0_addr_i,
  output logic                         m0_gnt_o,
  output logic                         m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]        m0_rdata_o,
  output logic                         m0_err_o,
  input  logic                         m1_req_i,
  input  logic [ADDR_WIDTH-1:0]        m1_addr_i,
  input  logic                         m1_we_i,
  input  logic [DATA_WIDTH/8-1:0]      m1_be_i,
  input  logic [DATA_WIDTH-1:0]        m1_wdata_i,
  output logic                         m1_gnt_o,
  output logic                         m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]        m1_rdata_o,
  output logic                         m1_err_o,
  output logic                         ram_en_o,
  output logic [DATA_WIDTH/8-1:0]      ram_we_o,
  output logic [$clog2(MEM_WORDS)-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0]        ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]        ram_rdata_i
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);
  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned TOP_SHIFT = IDX_W + OFF_W;

  // 1 = m1 was granted most recently, so m0 wins the next conflict
  logic last_grant;
  logic resp_valid;
  logic resp_owner;
  logic resp_err;
  logic resp_is_write;

  logic                  any_gnt;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] resp_rdata;

  // Combinational grant and RAM request path; nothing is granted during reset
  always_comb begin
    m0_gnt_o    = 1'b0;
    m1_gnt_o    = 1'b0;
    sel_addr    = '0;
    any_gnt     = 1'b0;
    in_range    = 1'b0;
    ram_en_o    = 1'b0;
    ram_we_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;

    if (!rst_i) begin
      if (m0_req_i && m1_req_i) begin
        m0_gnt_o = last_grant;
        m1_gnt_o = !last_grant;
      end else begin
        m0_gnt_o = m0_req_i;
        m1_gnt_o = m1_req_i;
      end
    end

    any_gnt  = m0_gnt_o || m1_gnt_o;
    sel_addr = m1_gnt_o ? m1_addr_i : m0_addr_i;
    in_range = ((sel_addr >> TOP_SHIFT) == '0);

    if (any_gnt && in_range) begin
      ram_en_o    = 1'b1;
      ram_we_o    = (m1_gnt_o && m1_we_i) ? m1_be_i : '0;
      ram_addr_o  = IDX_W'(sel_addr >> OFF_W);
      ram_wdata_o = m1_wdata_i;
    end
  end

  // Arbitration history and the single-entry response register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant    <= 1'b1;
      resp_valid    <= 1'b0;
      resp_owner    <= 1'b0;
      resp_err      <= 1'b0;
      resp_is_write <= 1'b0;
    end else begin
      resp_valid <= any_gnt;
      if (any_gnt) begin
        last_grant    <= m1_gnt_o;
        resp_owner    <= m1_gnt_o;
        resp_err      <= !in_range;
        resp_is_write <= m1_gnt_o && m1_we_i;
      end
    end
  end

  // Route the response to its owner; only in-range reads carry RAM data
  always_comb begin
    resp_rdata  = (resp_valid && !resp_err && !resp_is_write) ? ram_rdata_i : '0;
    m0_rvalid_o = resp_valid && !resp_owner;
    m1_rvalid_o = resp_valid && resp_owner;
    m0_rdata_o  = m0_rvalid_o ? resp_rdata : '0;
    m1_rdata_o  = m1_rvalid_o ? resp_rdata : '0;
    m0_err_o    = m0_rvalid_o && resp_err;
    m1_err_o    = m1_rvalid_o && resp_err;
  end

endmodule
